// File: rtl/wb_writer.sv
// Integer register-file writeback: merges ALU results and FIFO-buffered load results into one
// registered, active-low write per cycle. Define WB_STARVE_GUARD_EN to bound load starvation.
module wb_writer #(
   parameter int DATA_W   = 32,
   parameter int IDX_W    = 5,
   parameter int LQ_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid_i,
   input  logic [IDX_W-1:0]  alu_rd_i,
   input  logic [DATA_W-1:0] alu_data_i,
   input  logic              lsu_valid_i,
   output logic              lsu_ready_o,
   input  logic [IDX_W-1:0]  lsu_rd_i,
   input  logic [DATA_W-1:0] lsu_data_i,
   output logic              wen_o,
   output logic [IDX_W-1:0]  rd_idx_o,
   output logic [DATA_W-1:0] rd_wdata_o,
   output logic              busy_o,
   output logic              alu_stall_o
);

   localparam int PTR_W = $clog2(LQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LQ_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [IDX_W-1:0]  lq_rd_q   [LQ_DEPTH];
   logic [DATA_W-1:0] lq_data_q [LQ_DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              wen_q, wen_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] data_q, data_d;

   logic full, empty, push, pop, alu_win;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);

   // Ready looks only at the registered count, so a pop in this cycle does not reopen it.
   assign lsu_ready_o = rst_n & ~full;
   assign busy_o      = rst_n & ~empty;

   // Loads to x0 finish the handshake but never occupy a slot.
   assign push    = lsu_valid_i & lsu_ready_o & (lsu_rd_i != '0);
   assign alu_win = alu_valid_i & ~alu_stall_o & (alu_rd_i != '0);
   assign pop     = ~alu_win & ~empty;

`ifdef WB_STARVE_GUARD_EN
   logic [2:0] starve_q, starve_d;

   assign alu_stall_o = rst_n & (starve_q == 3'd7);

   always_comb begin
      starve_d = starve_q;
      if (empty || pop) begin
         starve_d = 3'd0;
      end else begin
         starve_d = starve_q + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_q <= 3'd0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   assign alu_stall_o = 1'b0;
`endif

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      wen_d    = 1'b1;
      idx_d    = idx_q;
      data_d   = data_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      if (alu_win) begin
         wen_d  = 1'b0;
         idx_d  = alu_rd_i;
         data_d = alu_data_i;
      end else if (pop) begin
         wen_d  = 1'b0;
         idx_d  = lq_rd_q[rd_ptr_q];
         data_d = lq_data_q[rd_ptr_q];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         wen_q    <= 1'b1;
         idx_q    <= '0;
         data_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         wen_q    <= wen_d;
         idx_q    <= idx_d;
         data_q   <= data_d;
      end
   end

   // Payload storage needs no reset: a slot is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push) begin
         lq_rd_q[wr_ptr_q]   <= lsu_rd_i;
         lq_data_q[wr_ptr_q] <= lsu_data_i;
      end
   end

   assign wen_o      = wen_q;
   assign rd_idx_o   = idx_q;
   assign rd_wdata_o = data_q;

endmodule

// File: tb/tb_wb_writer.sv
// Bench for wb_writer: directed vector table, hand-written corner sequences and random traffic,
// all checked against a queue-based reference model of the writeback rules.
module tb_wb_writer;

  localparam int DW = 32;
  localparam int IW = 5;
  localparam int LQ = 4;
`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid_i;
  logic [IW-1:0] alu_rd_i;
  logic [DW-1:0] alu_data_i;
  logic          lsu_valid_i;
  logic          lsu_ready_o;
  logic [IW-1:0] lsu_rd_i;
  logic [DW-1:0] lsu_data_i;
  logic          wen_o;
  logic [IW-1:0] rd_idx_o;
  logic [DW-1:0] rd_wdata_o;
  logic          busy_o;
  logic          alu_stall_o;

  always #5 clk = ~clk;

  wb_writer #(.DATA_W(DW), .IDX_W(IW), .LQ_DEPTH(LQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid_i(alu_valid_i),
    .alu_rd_i   (alu_rd_i),
    .alu_data_i (alu_data_i),
    .lsu_valid_i(lsu_valid_i),
    .lsu_ready_o(lsu_ready_o),
    .lsu_rd_i   (lsu_rd_i),
    .lsu_data_i (lsu_data_i),
    .wen_o      (wen_o),
    .rd_idx_o   (rd_idx_o),
    .rd_wdata_o (rd_wdata_o),
    .busy_o     (busy_o),
    .alu_stall_o(alu_stall_o)
  );

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds the loads the block should be holding, oldest first, as {rd, data}.
  logic [IW+DW-1:0] exp_q[$];
  logic             m_ready, m_busy, m_stall;
  logic             m_wen;
  logic [IW-1:0]    m_idx;
  logic [DW-1:0]    m_data;
  int               m_wait;     // cycles the oldest queued load has been passed over
  logic             s_ready, s_busy, s_stall;
  int               n_tests = 0;
  int               n_fail  = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_comb();
    m_ready = rst_n && (exp_q.size() < LQ);
    m_busy  = rst_n && (exp_q.size() != 0);
    m_stall = GUARD && rst_n && (m_wait >= 7);
  endfunction

  function automatic void model_edge();
    logic [IW+DW-1:0] ent;
    bit popped;
    bit was_empty;
    popped    = 1'b0;
    was_empty = (exp_q.size() == 0);
    if (!rst_n) begin
      exp_q.delete();
      m_wen  = 1'b1;
      m_idx  = '0;
      m_data = '0;
      m_wait = 0;
    end else begin
      if (alu_valid_i && !m_stall && alu_rd_i != 0) begin
        m_wen  = 1'b0;
        m_idx  = alu_rd_i;
        m_data = alu_data_i;
      end else if (!was_empty) begin
        ent    = exp_q.pop_front();
        m_wen  = 1'b0;
        m_idx  = ent[IW+DW-1:DW];
        m_data = ent[DW-1:0];
        popped = 1'b1;
      end else begin
        m_wen = 1'b1;
      end
      if (lsu_valid_i && m_ready && lsu_rd_i != 0) exp_q.push_back({lsu_rd_i, lsu_data_i});
      m_wait = (popped || was_empty) ? 0 : m_wait + 1;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic av, input logic [IW-1:0] ard, input logic [DW-1:0] adat,
                        input logic lv, input logic [IW-1:0] lrd, input logic [DW-1:0] ldat);
    alu_valid_i = av;
    alu_rd_i    = ard;
    alu_data_i  = adat;
    lsu_valid_i = lv;
    lsu_rd_i    = lrd;
    lsu_data_i  = ldat;
  endtask

  task automatic idle();
    set_in(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // One clock: combinational outputs checked at the falling edge, registered ones after the rise.
  task automatic step();
    @(negedge clk);
    model_comb();
    s_ready = lsu_ready_o;
    s_busy  = busy_o;
    s_stall = alu_stall_o;
    check("lsu_ready_o", lsu_ready_o, m_ready);
    check("busy_o", busy_o, m_busy);
    check("alu_stall_o", alu_stall_o, m_stall);
    model_edge();
    @(posedge clk);
    #1;
    check("wen_o", wen_o, m_wen);
    check("rd_idx_o", rd_idx_o, m_idx);
    check("rd_wdata_o", rd_wdata_o, m_data);
  endtask

  task automatic drain(string name);
    int n;
    idle();
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    step();
    check({name, "_drain_busy"}, busy_o, 1'b0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          av;
    logic [IW-1:0] ard;
    logic [DW-1:0] adat;
    logic          lv;
    logic [IW-1:0] lrd;
    logic [DW-1:0] ldat;
    logic          e_ready;
    logic          e_busy;
    logic          e_wen;
    logic [IW-1:0] e_idx;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int hits;
    m_wen = 1'b1; m_idx = '0; m_data = '0; m_wait = 0;

    //            av    ard    adat           lv    lrd    ldat      rdy   busy  wen   idx    data
    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h11, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 5'd0, 32'h55,       1'b1, 5'd0, 32'h99, 1'b1, 1'b1, 1'b0, 5'd3, 32'h11};
    vecs[4] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 5'd3, 32'h11};
    vecs[5] = '{1'b1, 5'd7, 32'h1234,     1'b1, 5'd9, 32'hAA, 1'b1, 1'b0, 1'b0, 5'd7, 32'h1234};
    vecs[6] = '{1'b1, 5'd8, 32'h5678,     1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd8, 32'h5678};
    vecs[7] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd9, 32'hAA};
    vecs[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 5'd9, 32'hAA};

    // Reset
    rst_n = 1'b0;
    idle();
    step();
    step();
    check("reset_wen", wen_o, 1'b1);
    check("reset_idx", rd_idx_o, 0);
    check("reset_data", rd_wdata_o, 0);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      set_in(vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].lv, vecs[i].lrd, vecs[i].ldat);
      step();
      check($sformatf("vec%0d_ready", i), s_ready, vecs[i].e_ready);
      check($sformatf("vec%0d_busy", i), s_busy, vecs[i].e_busy);
      check($sformatf("vec%0d_wen", i), wen_o, vecs[i].e_wen);
      check($sformatf("vec%0d_idx", i), rd_idx_o, vecs[i].e_idx);
      check($sformatf("vec%0d_data", i), rd_wdata_o, vecs[i].e_data);
    end

    // Full boundary: ALU holds the port while five loads are offered
    k = 0;
    for (int c = 0; c < 8; c++) begin
      set_in(1'b1, IW'(1 + c), $urandom, 1'b1, IW'(10 + k), DW'(32'h100 + k));
      step();
      if (s_ready) k++;
    end
    check("full_accepts", k, 4);
    check("full_ready_low", s_ready, 1'b0);
    set_in(1'b0, '0, '0, 1'b1, IW'(10 + k), DW'(32'h100 + k));
    step();
    check("full_ready_held_on_pop", s_ready, 1'b0);
    check("full_first_pop_idx", rd_idx_o, 10);
    step();
    check("full_ready_back", s_ready, 1'b1);
    drain("full");

    // Pointer wrap: ten loads with the ALU taking every other cycle
    k = 0;
    for (int c = 0; c < 40 && k < 10; c++) begin
      set_in(c % 2 == 0, IW'($urandom_range(1, 31)), $urandom, 1'b1, IW'(k + 1), DW'(32'hA000 + k));
      step();
      if (s_ready) k++;
    end
    check("wrap_accepts", k, 10);
    drain("wrap");

    // Starvation: one queued load under a continuous ALU stream
    set_in(1'b1, 5'd1, $urandom, 1'b1, 5'd17, 32'hCAFE);
    step();
    hits = 0;
    for (int c = 0; c < 20; c++) begin
      set_in(1'b1, IW'($urandom_range(1, 16)), $urandom, 1'b0, '0, '0);
      step();
      if (!wen_o && rd_idx_o == 5'd17) hits++;
    end
    check("starve_load_written", hits, int'(GUARD));
    drain("starve");

    // Reset with three loads queued
    for (int c = 0; c < 3; c++) begin
      set_in(1'b1, 5'd5, $urandom, 1'b1, IW'(20 + c), $urandom);
      step();
    end
    check("rst_pre_busy", s_busy, 1'b1);
    rst_n = 1'b0;
    step();
    check("rst_ready", s_ready, 1'b0);
    check("rst_busy", s_busy, 1'b0);
    check("rst_wen", wen_o, 1'b1);
    step();
    rst_n = 1'b1;
    idle();
    step();
    check("post_rst_ready", s_ready, 1'b1);
    check("post_rst_busy", s_busy, 1'b0);
    check("post_rst_wen", wen_o, 1'b1);
    step();
    step();

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      set_in($urandom_range(0, 99) < 60,
             ($urandom_range(0, 3) == 0) ? IW'(0) : IW'($urandom_range(1, 31)),
             $urandom,
             $urandom_range(0, 99) < 50,
             ($urandom_range(0, 3) == 0) ? IW'(0) : IW'($urandom_range(1, 31)),
             $urandom);
      step();
    end
    rst_n = 1'b1;
    drain("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
